pix_clk_gen: RTL
================

# pix_clk_gen

Parametrised pixel-clock generator for the LCD/VGA display path. It divides the system clock by a runtime-programmable ratio and produces two outputs: a one-cycle pixel-enable `tick` and a registered divided clock `pix_clk`. The block replaces the fixed divide-by-4 pixel clock. Downstream timing generators use `tick` as their clock enable and `phase` for sub-pixel alignment.

## Interface
- `CNT_W`, 8: width of the divisor, counter and `phase`.
- `DEFAULT_DIV`, 4: divisor loaded at reset. Legal range 2..2^CNT_W−1.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: count enable. When low, the counter and `pix_clk` hold.
- `restart` in 1: synchronous one-cycle phase restart.
- `div_valid` in 1: new divisor offered.
- `div_data` in CNT_W: new divisor value.
- `div_ready` out 1: divisor load accepted when high.
- `tick` out 1: one-cycle pulse, once per period.
- `pix_clk` out 1: registered divided clock.
- `phase` out CNT_W: current count, 0..div−1.

## Operation
- Registers: `div`, `count`, `pend_div`, `pend_flag`, `tick`, `pix_clk`.
- Reset values: `div`=DEFAULT_DIV, `count`=0, `pend_flag`=0, `tick`=0, `pix_clk`=0, `div_ready`=1, `phase`=0.
- Counting (en=1, restart=0):
  - `count` increments by 1 each edge.
  - At `count`==div−1 it wraps to 0. This edge is the "wrap edge".
- `tick` is registered: it is high for exactly the cycle following a wrap edge, otherwise 0. When en=0, `tick`=0.
- `pix_clk` is a flop. Its value always equals (`count` ≥ div − (div>>1)).
  - High for floor(div/2) cycles and low for ceil(div/2) cycles per period.
  - The falling edge coincides with `tick` rising.
- Divisor load handshake:
  - `div_ready` = !`pend_flag`.
  - On an edge with `div_valid` && `div_ready`: capture `pend_div` ← max(`div_data`, 2) and set `pend_flag`.
  - `div_data` values 0 or 1 are clamped to 2.
- Applying a pending divisor:
  - On the next wrap edge, `div` ← `pend_div` and `pend_flag` clears. `count` still goes to 0, so the new period starts cleanly.
  - If en=0 on an edge where `pend_flag`=1, the divisor is applied immediately and `count` is forced to 0.
- `restart`:
  - On an edge with `restart`=1: `count`←0, `pix_clk`←0, `tick`←0, and any pending divisor is applied.
  - `restart` has priority over `en`, the wrap, and a handshake capture on the same edge. On that edge `div_valid` is not accepted, because `div_ready` is recomputed afterwards.
- `phase` = `count`, registered with no extra latency.

## Timing
- With en=1 from reset and div=D, `tick` is first high after the D-th enabled edge, then every D edges.
- Latency from handshake to effect: the divisor takes effect at the first wrap edge after the acceptance edge. If acceptance happens on a wrap edge, the new value applies at the following wrap edge.
- `div_ready` drops the edge after acceptance and rises the edge after the divisor is applied.
- If en=0 mid-period, `count` and `pix_clk` freeze; resuming continues from the frozen `count`.
- Asserting `rst_n` mid-period forces all reset values immediately, with no cycle delay.

## Configuration
- `PIXCLK_DUTY50_EN` defined: `pix_clk` is the balanced divided clock described above.
- Not defined: the duty logic is removed. `pix_clk` is driven identically to `tick`, giving a one-cycle-high pulse that matches the legacy pixel clock.

## Test plan
- Reset with DEFAULT_DIV=4 and en=1 held → `tick` high on cycles 4, 8, 12. `pix_clk` is high during `phase` 2–3 and low during 0–1. `phase` sequence is 0,1,2,3,0.
- Load div_data=5 mid-period (accepted at `phase`=1) → `div_ready` goes 0. The current period still ends at 4, then the periods are 5 cycles. `pix_clk` is high during `phase` 3–4 (2 cycles). `div_ready` returns to 1 after the wrap.
- Load div_data=0 → clamped to 2. `tick` occurs every 2 cycles and `pix_clk` toggles every cycle.
- Drop en for 3 cycles at `phase`=2 → `phase` holds at 2, `tick`=0 throughout. The period then completes 3 cycles late.
- Pulse `restart` at `phase`=3 while div_data=6 is pending → next cycle `phase`=0, `tick`=0, `pix_clk`=0, div=6. `div_ready`=1 on the following cycle.
- Build without `PIXCLK_DUTY50_EN` → `pix_clk` equals `tick` on every cycle across div=4 and div=7.

Source files
------------

// File: rtl/pix_clk_if.sv
// Divisor-load handshake between a display controller (master) and pix_clk_gen (slave).
interface pix_clk_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             div_valid;
    logic [CNT_W-1:0] div_data;
    logic             div_ready;

    modport master (output div_valid, output div_data, input  div_ready);
    modport slave  (input  div_valid, input  div_data, output div_ready);
endinterface

// File: rtl/pix_clk_gen.sv
// Runtime-programmable pixel-clock divider producing a pixel-enable tick and a divided clock.
// Define PIXCLK_DUTY50_EN for a balanced pix_clk; otherwise pix_clk mirrors tick.
module pix_clk_gen #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    pix_clk_if.slave         div_if,
    output logic             tick,
    output logic             pix_clk,
    output logic [CNT_W-1:0] phase
);
    localparam logic [CNT_W-1:0] One = CNT_W'(1);
    localparam logic [CNT_W-1:0] Two = CNT_W'(2);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_flag_q, pend_flag_d;
    logic             tick_q, tick_d;
    logic             pix_clk_q, pix_clk_d;
    logic             wrap, accept, apply;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= CNT_W'(DEFAULT_DIV);
            count_q     <= '0;
            pend_div_q  <= '0;
            pend_flag_q <= 1'b0;
            tick_q      <= 1'b0;
            pix_clk_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            count_q     <= count_d;
            pend_div_q  <= pend_div_d;
            pend_flag_q <= pend_flag_d;
            tick_q      <= tick_d;
            pix_clk_q   <= pix_clk_d;
        end
    end

    always_comb begin
        wrap   = en && (count_q == div_q - One);
        // restart wins over a same-edge load offer; ready is only re-evaluated afterwards
        accept = div_if.div_valid && !pend_flag_q && !restart;
        apply  = pend_flag_q && (restart || !en || wrap);

        div_d       = apply ? pend_div_q : div_q;
        pend_div_d  = pend_div_q;
        pend_flag_d = pend_flag_q;
        if (apply) begin
            pend_flag_d = 1'b0;
        end
        if (accept) begin
            pend_flag_d = 1'b1;
            pend_div_d  = (div_if.div_data < Two) ? Two : div_if.div_data;
        end

        if (restart || wrap || apply) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + One;
        end else begin
            count_d = count_q;
        end

        tick_d = wrap && !restart;
`ifdef PIXCLK_DUTY50_EN
        // High for the last floor(div/2) counts so the falling edge lands on the wrap
        pix_clk_d = (count_d >= div_d - (div_d >> 1));
`else
        pix_clk_d = tick_d;
`endif
    end

    assign div_if.div_ready = !pend_flag_q;
    assign tick             = tick_q;
    assign pix_clk          = pix_clk_q;
    assign phase            = count_q;
endmodule
